// File: rtl/dport_arb_pkg.sv
// Shared constants and helpers for the data-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: port identifiers, bus widths, request-valid helper.
package dport_arb_pkg;

  localparam logic PORT_IN0 = 1'b0;
  localparam logic PORT_IN1 = 1'b1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 11;
  localparam int STRB_W = 4;

  // A requester is active when it reads or drives any write strobe.
  function automatic logic req_valid(input logic rd, input logic [STRB_W-1:0] wr);
    return rd | (wr != '0);
  endfunction

endpackage

// File: rtl/dport_arb_order_fifo.sv
// Ordering FIFO: remembers which requester owns each in-flight request.
// Latency: push visible at head one cycle later; pop is same-cycle on head.
// Backpressure: accept_o low when full; pushes/pops are ignored when not allowed.
// Ports: clk_i, rst_i (sync active-low), push_i/push_dat_i, pop_i,
//        valid_o (not empty), accept_o (not full), head_o, count_o.
module dport_arb_order_fifo #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             push_dat_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             accept_o,
  output logic             head_o,
  output logic [DEPTH_W:0] count_o
);

  localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W+1)'(DEPTH);

  logic [DEPTH-1:0]   r_mem;
  logic [DEPTH_W-1:0] r_wr_ptr;
  logic [DEPTH_W-1:0] r_rd_ptr;
  logic [DEPTH_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign valid_o  = (r_count != '0);
  assign accept_o = (r_count != FULL_CNT);
  assign head_o   = r_mem[r_rd_ptr];
  assign count_o  = r_count;
  assign w_push   = push_i & accept_o;
  assign w_pop    = pop_i & valid_o;

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_dat_i;
  end

  // Pointers are DEPTH_W wide so they wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dport_arb.sv
// Two-requester arbiter sharing one data-port memory interface; acks routed in order.
// Latency: zero-cycle request pass-through; acks routed combinationally from the ordering FIFO head.
// Backpressure: grant held on the presented port until out_accept_i; all requests stall while OUTSTANDING are unacked.
// Ports: in0_*/in1_* requester side, out_* downstream bridge side,
//        outstanding_o (in-flight count), spurious_o (sticky ack-while-empty flag).
module dport_arb
  import dport_arb_pkg::*;
#(
  parameter int OUTSTANDING   = 4,
  parameter int OUTSTANDING_W = 2,
  parameter int FIXED_PRIO    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    in0_addr_i,
  input  logic [DATA_W-1:0]    in0_data_wr_i,
  input  logic                 in0_rd_i,
  input  logic [STRB_W-1:0]    in0_wr_i,
  input  logic [TAG_W-1:0]     in0_req_tag_i,
  output logic                 in0_accept_o,
  output logic                 in0_ack_o,
  output logic [DATA_W-1:0]    in0_data_rd_o,
  output logic                 in0_error_o,
  output logic [TAG_W-1:0]     in0_resp_tag_o,
  input  logic [ADDR_W-1:0]    in1_addr_i,
  input  logic [DATA_W-1:0]    in1_data_wr_i,
  input  logic                 in1_rd_i,
  input  logic [STRB_W-1:0]    in1_wr_i,
  input  logic [TAG_W-1:0]     in1_req_tag_i,
  output logic                 in1_accept_o,
  output logic                 in1_ack_o,
  output logic [DATA_W-1:0]    in1_data_rd_o,
  output logic                 in1_error_o,
  output logic [TAG_W-1:0]     in1_resp_tag_o,
  output logic [ADDR_W-1:0]    out_addr_o,
  output logic [DATA_W-1:0]    out_data_wr_o,
  output logic                 out_rd_o,
  output logic [STRB_W-1:0]    out_wr_o,
  output logic [TAG_W-1:0]     out_req_tag_o,
  input  logic                 out_accept_i,
  input  logic                 out_ack_i,
  input  logic [DATA_W-1:0]    out_data_rd_i,
  input  logic                 out_error_i,
  input  logic [TAG_W-1:0]     out_resp_tag_i,
  output logic [OUTSTANDING_W:0] outstanding_o,
  output logic                 spurious_o
);

  logic r_hold;
  logic r_hold_src;
  logic r_last;
  logic r_spurious;

  logic w_req0;
  logic w_req1;
  logic w_grant;
  logic w_grant_vld;
  logic w_accept;
  logic w_fifo_vld;
  logic w_fifo_rdy;
  logic w_head;
  logic w_pop;

  assign w_req0 = req_valid(in0_rd_i, in0_wr_i);
  assign w_req1 = req_valid(in1_rd_i, in1_wr_i);

  // A held request owns the port until accepted, so a late-arriving
  // competitor can never change the fields under the bridge's feet.
  always_comb begin
    w_grant = PORT_IN0;
    if (r_hold)                 w_grant = r_hold_src;
    else if (w_req0 && !w_req1) w_grant = PORT_IN0;
    else if (w_req1 && !w_req0) w_grant = PORT_IN1;
    else if (w_req0 && w_req1)  w_grant = (FIXED_PRIO != 0) ? PORT_IN0 : ~r_last;
  end

  // Full comes from the registered count only: an ack this cycle frees a
  // slot for next cycle, not this one.
  assign w_grant_vld = (r_hold | w_req0 | w_req1) & w_fifo_rdy;
  assign w_accept    = w_grant_vld & out_accept_i;

  assign out_addr_o    = (w_grant == PORT_IN1) ? in1_addr_i    : in0_addr_i;
  assign out_data_wr_o = (w_grant == PORT_IN1) ? in1_data_wr_i : in0_data_wr_i;
  assign out_req_tag_o = (w_grant == PORT_IN1) ? in1_req_tag_i : in0_req_tag_i;
  assign out_rd_o      = w_grant_vld & ((w_grant == PORT_IN1) ? in1_rd_i : in0_rd_i);
  assign out_wr_o      = w_grant_vld ? ((w_grant == PORT_IN1) ? in1_wr_i : in0_wr_i) : '0;

  assign in0_accept_o = w_accept & (w_grant == PORT_IN0);
  assign in1_accept_o = w_accept & (w_grant == PORT_IN1);

  // Bridge responds in issue order, so the FIFO head names the owner.
  assign w_pop     = out_ack_i & w_fifo_vld;
  assign in0_ack_o = w_pop & (w_head == PORT_IN0);
  assign in1_ack_o = w_pop & (w_head == PORT_IN1);

  assign in0_data_rd_o  = out_data_rd_i;
  assign in1_data_rd_o  = out_data_rd_i;
  assign in0_error_o    = out_error_i;
  assign in1_error_o    = out_error_i;
  assign in0_resp_tag_o = out_resp_tag_i;
  assign in1_resp_tag_o = out_resp_tag_i;

  assign spurious_o = r_spurious;

  dport_arb_order_fifo #(
    .DEPTH   (OUTSTANDING),
    .DEPTH_W (OUTSTANDING_W)
  ) u_order_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (w_accept),
    .push_dat_i (w_grant),
    .pop_i      (w_pop),
    .valid_o    (w_fifo_vld),
    .accept_o   (w_fifo_rdy),
    .head_o     (w_head),
    .count_o    (outstanding_o)
  );

  // last resets to in1 so the first tie after reset goes to in0.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_hold     <= 1'b0;
      r_hold_src <= PORT_IN0;
      r_last     <= PORT_IN1;
      r_spurious <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold <= 1'b0;
        r_last <= w_grant;
      end else if (w_grant_vld) begin
        r_hold     <= 1'b1;
        r_hold_src <= w_grant;
      end
      if (out_ack_i && !w_fifo_vld) r_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dport_arb.sv
// Randomized + directed bench for dport_arb with a scoreboard on routed acks.
// Latency: n/a.
// Backpressure: bench requesters hold requests until accepted.
module tb_dport_arb;
  import dport_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a0, a1, d0, d1;
  logic        rd0, rd1;
  logic [3:0]  wr0, wr1;
  logic [10:0] t0, t1;
  logic        acc0, acc1, ack0, ack1, err0, err1;
  logic [31:0] drd0, drd1;
  logic [10:0] rt0, rt1;
  logic [31:0] o_addr, o_dwr;
  logic        o_rd;
  logic [3:0]  o_wr;
  logic [10:0] o_tag;
  logic        o_acc, o_ack, o_err;
  logic [31:0] o_drd;
  logic [10:0] o_rtag;
  logic [2:0]  outst;
  logic        spur;

  // Second instance with fixed priority; only accepts are examined.
  logic        fp_rd, fp_ack_in;
  logic        fp_acc0, fp_acc1, fp_ack0, fp_ack1, fp_err0, fp_err1, fp_ord, fp_spur;
  logic [31:0] fp_drd0, fp_drd1, fp_oaddr, fp_odwr;
  logic [10:0] fp_rt0, fp_rt1, fp_otag;
  logic [3:0]  fp_owr;
  logic [2:0]  fp_outst;
  assign fp_ack_in = (fp_outst != 3'd0);

  dport_arb #(.OUTSTANDING(4), .OUTSTANDING_W(2), .FIXED_PRIO(0)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .in0_addr_i(a0), .in0_data_wr_i(d0), .in0_rd_i(rd0), .in0_wr_i(wr0), .in0_req_tag_i(t0),
    .in0_accept_o(acc0), .in0_ack_o(ack0), .in0_data_rd_o(drd0), .in0_error_o(err0), .in0_resp_tag_o(rt0),
    .in1_addr_i(a1), .in1_data_wr_i(d1), .in1_rd_i(rd1), .in1_wr_i(wr1), .in1_req_tag_i(t1),
    .in1_accept_o(acc1), .in1_ack_o(ack1), .in1_data_rd_o(drd1), .in1_error_o(err1), .in1_resp_tag_o(rt1),
    .out_addr_o(o_addr), .out_data_wr_o(o_dwr), .out_rd_o(o_rd), .out_wr_o(o_wr), .out_req_tag_o(o_tag),
    .out_accept_i(o_acc), .out_ack_i(o_ack), .out_data_rd_i(o_drd), .out_error_i(o_err),
    .out_resp_tag_i(o_rtag), .outstanding_o(outst), .spurious_o(spur));

  dport_arb #(.OUTSTANDING(4), .OUTSTANDING_W(2), .FIXED_PRIO(1)) u_dut_fp (
    .clk_i(clk), .rst_i(rst_n),
    .in0_addr_i(a0), .in0_data_wr_i(d0), .in0_rd_i(fp_rd), .in0_wr_i(4'b0000), .in0_req_tag_i(t0),
    .in0_accept_o(fp_acc0), .in0_ack_o(fp_ack0), .in0_data_rd_o(fp_drd0), .in0_error_o(fp_err0), .in0_resp_tag_o(fp_rt0),
    .in1_addr_i(a1), .in1_data_wr_i(d1), .in1_rd_i(fp_rd), .in1_wr_i(4'b0000), .in1_req_tag_i(t1),
    .in1_accept_o(fp_acc1), .in1_ack_o(fp_ack1), .in1_data_rd_o(fp_drd1), .in1_error_o(fp_err1), .in1_resp_tag_o(fp_rt1),
    .out_addr_o(fp_oaddr), .out_data_wr_o(fp_odwr), .out_rd_o(fp_ord), .out_wr_o(fp_owr), .out_req_tag_o(fp_otag),
    .out_accept_i(1'b1), .out_ack_i(fp_ack_in), .out_data_rd_i(o_drd), .out_error_i(o_err),
    .out_resp_tag_i(o_rtag), .outstanding_o(fp_outst), .spurious_o(fp_spur));

  typedef struct { bit src; logic [10:0] tag; } resp_t;

  int    checks = 0;
  int    errors = 0;
  resp_t sb_q[$];        // expected responses, in acceptance order
  bit    src_q[$];       // owners of in-flight requests
  logic [10:0] br_q[$];  // tags the bridge model still owes a response for
  bit    m_last, m_hold, m_hsrc, m_spur;
  bit    last_acc0, last_acc1;
  resp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: who should be granted, what the bridge sees, and who gets each ack.
  task automatic model_check();
    bit r0, r1, full, g, v, a, pop;
    int cnt;
    if (!rst_n) begin
      src_q.delete(); sb_q.delete(); br_q.delete();
      m_last = 1'b1; m_hold = 1'b0; m_hsrc = 1'b0; m_spur = 1'b0;
      last_acc0 = 1'b0; last_acc1 = 1'b0;
      return;
    end
    r0   = rd0 | (wr0 != 4'd0);
    r1   = rd1 | (wr1 != 4'd0);
    cnt  = src_q.size();
    full = (cnt == 4);
    if (m_hold)         g = m_hsrc;
    else if (r0 && r1)  g = !m_last;
    else                g = r1;
    v   = (m_hold | r0 | r1) & !full;
    a   = v & o_acc;
    pop = o_ack && (cnt > 0);
    chk("accept0", 32'(acc0), 32'(a & !g));
    chk("accept1", 32'(acc1), 32'(a & g));
    chk("out_rd", 32'(o_rd), 32'(v & (g ? rd1 : rd0)));
    chk("out_wr", 32'(o_wr), v ? 32'(g ? wr1 : wr0) : 32'd0);
    if (v) begin
      chk("out_addr", o_addr, g ? a1 : a0);
      chk("out_data_wr", o_dwr, g ? d1 : d0);
      chk("out_req_tag", 32'(o_tag), 32'(g ? t1 : t0));
    end
    chk("ack0", 32'(ack0), 32'(pop && src_q[0] == 1'b0));
    chk("ack1", 32'(ack1), 32'(pop && src_q[0] == 1'b1));
    chk("bcast_data1", drd1, o_drd);
    chk("bcast_err", 32'({err0, err1}), 32'({o_err, o_err}));
    chk("outstanding", 32'(outst), 32'(cnt));
    chk("spurious", 32'(spur), 32'(m_spur));
    if (o_ack && br_q.size() > 0) void'(br_q.pop_front());
    if (a) br_q.push_back(o_tag);
    if (pop) void'(src_q.pop_front());
    if (a) begin
      src_q.push_back(g);
      sb_q.push_back('{g, g ? t1 : t0});
      m_last = g; m_hold = 1'b0;
    end else if (v) begin
      m_hold = 1'b1; m_hsrc = g;
    end
    if (o_ack && cnt == 0) m_spur = 1'b1;
    last_acc0 = a && !g;
    last_acc1 = a && g;
  endtask

  // Scoreboard consumer: every routed ack must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ack0 || ack1)) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: ack0=%0b ack1=%0b expected none", ack0, ack1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp_onehot", 32'(ack0 & ack1), 32'd0);
        chk("resp_port", 32'(ack1), 32'(mon_e.src));
        chk("resp_tag0", 32'(rt0), 32'(mon_e.tag));
        chk("resp_tag1", 32'(rt1), 32'(mon_e.tag));
        chk("resp_data", drd0, o_drd);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit rd, input logic [3:0] wr,
                          input logic [31:0] addr, input logic [10:0] tag);
    if (p == 0) begin rd0 = rd; wr0 = wr; a0 = addr; t0 = tag; d0 = $urandom; end
    else        begin rd1 = rd; wr1 = wr; a1 = addr; t1 = tag; d1 = $urandom; end
  endtask

  task automatic rand_port(input int p);
    case ($urandom_range(0, 2))
      0:       set_port(p, 1'b0, 4'd0, $urandom, 11'($urandom));
      1:       set_port(p, 1'b1, 4'd0, $urandom, 11'($urandom));
      default: set_port(p, 1'b0, 4'($urandom_range(1, 15)), $urandom, 11'($urandom));
    endcase
  endtask

  task automatic set_ack(input bit en, input logic [31:0] data);
    o_ack  = en && (br_q.size() > 0);
    o_rtag = o_ack ? br_q[0] : 11'($urandom);
    o_drd  = data;
    o_err  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst_n = 1'b0; fp_rd = 1'b0;
    set_port(0, 1'b0, 4'd0, 32'd0, 11'd0);
    set_port(1, 1'b0, 4'd0, 32'd0, 11'd0);
    o_acc = 1'b0; o_ack = 1'b0; o_drd = '0; o_err = 1'b0; o_rtag = '0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("rst_outstanding", 32'(outst), 32'd0);
    chk("rst_accepts", 32'({acc0, acc1}), 32'd0);

    // Single read on in0, acked two cycles later.
    set_port(0, 1'b1, 4'd0, 32'h100, 11'h005);
    o_acc = 1'b1;
    step();
    set_port(0, 1'b0, 4'd0, 32'd0, 11'd0);
    step();
    set_ack(1'b1, 32'hDEADBEEF);
    #1;
    chk("single_ack0", 32'(ack0), 32'd1);
    chk("single_tag", 32'(rt0), 32'h005);
    step();
    set_ack(1'b0, 32'd0);

    // Both ports request continuously: expect alternation, acks keep it flowing.
    for (int i = 0; i < 8; i++) begin
      if (last_acc0 || !rd0) set_port(0, 1'b1, 4'd0, $urandom, 11'($urandom));
      if (last_acc1 || !rd1) set_port(1, 1'b1, 4'd0, $urandom, 11'($urandom));
      set_ack(1'b1, $urandom);
      step();
    end
    set_port(0, 1'b0, 4'd0, 32'd0, 11'd0);
    set_port(1, 1'b0, 4'd0, 32'd0, 11'd0);
    for (int i = 0; i < 10 && br_q.size() > 0; i++) begin set_ack(1'b1, $urandom); step(); end
    set_ack(1'b0, 32'd0);

    // Hold: in1 presented but not accepted, in0 joins; grant must stay on in1.
    o_acc = 1'b0;
    set_port(1, 1'b0, 4'hF, 32'h200, 11'h011);
    step();
    set_port(0, 1'b1, 4'd0, 32'h300, 11'h022);
    step();
    #1;
    chk("hold_addr_in1", o_addr, 32'h200);
    step();
    o_acc = 1'b1;
    #1;
    chk("hold_release_in1", 32'(acc1), 32'd1);
    step();
    set_port(1, 1'b0, 4'd0, 32'd0, 11'd0);
    #1;
    chk("hold_then_in0", 32'(acc0), 32'd1);
    step();
    set_port(0, 1'b0, 4'd0, 32'd0, 11'd0);
    for (int i = 0; i < 10 && br_q.size() > 0; i++) begin set_ack(1'b1, $urandom); step(); end
    set_ack(1'b0, 32'd0);

    // Fill: in0,in1,in1,in0 with no acks, then a 5th request must stall.
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1'b0, 4'd0, 32'd0, 11'd0);
      set_port(1, 1'b0, 4'd0, 32'd0, 11'd0);
      set_port((i == 1 || i == 2) ? 1 : 0, 1'b1, 4'd0, $urandom, 11'(i + 8'h40));
      step();
    end
    set_port(1, 1'b0, 4'd0, 32'd0, 11'd0);
    set_port(0, 1'b1, 4'd0, 32'h500, 11'h055);
    #1;
    chk("full_outstanding", 32'(outst), 32'd4);
    chk("full_out_rd", 32'(o_rd), 32'd0);
    step();
    set_ack(1'b1, $urandom);
    #1;
    chk("full_ack_no_accept", 32'(acc0), 32'd0);
    step();
    set_ack(1'b0, 32'd0);
    step();
    set_port(0, 1'b0, 4'd0, 32'd0, 11'd0);
    for (int i = 0; i < 10 && br_q.size() > 0; i++) begin set_ack(1'b1, $urandom); step(); end

    // Ack with nothing outstanding.
    o_ack = 1'b1; o_rtag = 11'h7FF;
    step();
    o_ack = 1'b0;
    chk("spurious_set", 32'(spur), 32'd1);
    step();
    chk("spurious_held", 32'(spur), 32'd1);

    // Reset with two in flight, then a tie goes to in0.
    set_port(0, 1'b1, 4'd0, 32'h600, 11'h066); step();
    set_port(0, 1'b0, 4'd0, 32'd0, 11'd0);
    set_port(1, 1'b1, 4'd0, 32'h700, 11'h077); step();
    set_port(1, 1'b0, 4'd0, 32'd0, 11'd0);
    chk("pre_rst_outstanding", 32'(outst), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_outstanding", 32'(outst), 32'd0);
    chk("post_rst_spurious", 32'(spur), 32'd0);
    set_port(0, 1'b1, 4'd0, 32'h800, 11'h088);
    set_port(1, 1'b1, 4'd0, 32'h900, 11'h099);
    #1;
    chk("post_rst_tie_in0", 32'({acc0, acc1}), 32'b10);
    step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (last_acc0 || !(rd0 || wr0 != 4'd0)) rand_port(0);
      if (last_acc1 || !(rd1 || wr1 != 4'd0)) rand_port(1);
      o_acc = ($urandom_range(0, 3) != 0);
      set_ack(($urandom_range(0, 1) == 1), $urandom);
      step();
    end
    set_port(0, 1'b0, 4'd0, 32'd0, 11'd0);
    set_port(1, 1'b0, 4'd0, 32'd0, 11'd0);
    for (int i = 0; i < 10 && br_q.size() > 0; i++) begin set_ack(1'b1, $urandom); step(); end
    set_ack(1'b0, 32'd0);
    step();

    // Fixed-priority instance: in0 wins every tie while it requests.
    fp_rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fp_in0_wins", 32'(fp_acc0), 32'd1);
      chk("fp_in1_blocked", 32'(fp_acc1), 32'd0);
    end
    fp_rd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dport_arb.md
Name: dport_arb

Overview:
- Two-requester arbiter in front of the data-port AXI bridge. Shares one dcache_if-style memory port between in0 (core LSU) and in1 (debug/DMA master).
- Issues requests downstream in grant order.
- Records the source of each accepted request in an ordering FIFO.
- Routes the in-order downstream acks back to the owning requester.

Parameters:
- OUTSTANDING, 4: max accepted-but-unacked requests (ordering FIFO depth, power of 2).
- OUTSTANDING_W, 2: log2(OUTSTANDING).
- FIXED_PRIO, 0: 0 = round-robin between in0/in1; 1 = in0 always wins ties.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- in0_addr_i / in1_addr_i  in  32  request address
- in0_data_wr_i / in1_data_wr_i  in  32  write data
- in0_rd_i / in1_rd_i  in  1  read request
- in0_wr_i / in1_wr_i  in  4  write byte strobes (nonzero = write)
- in0_req_tag_i / in1_req_tag_i  in  11  request tag
- in0_accept_o / in1_accept_o  out  1  request accepted this cycle
- in0_ack_o / in1_ack_o  out  1  response for this requester
- in0_data_rd_o / in1_data_rd_o  out  32  read data (broadcast)
- in0_error_o / in1_error_o  out  1  response error (broadcast)
- in0_resp_tag_o / in1_resp_tag_o  out  11  response tag (broadcast)
- out_addr_o, out_data_wr_o  out  32  downstream address / write data
- out_rd_o  out  1  downstream read request
- out_wr_o  out  4  downstream write strobes
- out_req_tag_o  out  11  downstream tag
- out_accept_i  in  1  downstream accepted
- out_ack_i  in  1  downstream response valid
- out_data_rd_i  in  32  downstream read data
- out_error_i  in  1  downstream error
- out_resp_tag_i  in  11  downstream response tag
- outstanding_o  out  OUTSTANDING_W+1  current ordering-FIFO count
- spurious_o  out  1  sticky: ack received with no outstanding request

Behaviour:
- Request validity: reqN = inN_rd_i | (inN_wr_i != 0). full = (count_q == OUTSTANDING), taken from the registered count with no same-cycle pop bypass.
- Grant selection (combinational):
  - If hold_q = 1, grant = hold_src_q.
  - Else if only one port is requesting, grant that port.
  - Else if both are requesting: FIXED_PRIO=1 grants in0; FIXED_PRIO=0 grants the port other than last_q.
  - grant_vld = (hold_q | req0 | req1) & !full.
- Downstream mux: out_addr/data_wr/req_tag carry the granted port's fields. out_rd_o/out_wr_o carry the granted port's rd/wr when grant_vld, else 0.
- Accept: inN_accept_o = grant_vld & (grant==N) & out_accept_i. The other port's accept is 0. Zero-latency pass-through; the request is not registered.
- Hold:
  - hold_q <= 1 and hold_src_q <= grant when a downstream request is presented with out_accept_i = 0.
  - hold_q <= 0 on accept.
  - Requesters must keep the request stable until accepted. The arbiter never switches grant while hold_q = 1, even if the other port asserts.
- On accept: push grant into the ordering FIFO. last_q <= grant.
- Response routing:
  - inN_ack_o = out_ack_i & !empty & (head==N). Pop on out_ack_i & !empty.
  - data_rd, error and resp_tag are broadcast unmodified to both ports.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full: both accepts 0 and out_rd_o/out_wr_o = 0 until a pop lowers the count on the next cycle.
- Ack while empty: no inN_ack_o; spurious_o <= 1, held until reset.
- Pointers wrap modulo OUTSTANDING. Count saturates neither way; overflow cannot occur because push is gated by !full.
- Reset (synchronous, rst_i=0 at posedge):
  - count, pointers, hold_q, hold_src_q and spurious_o clear to 0; last_q <= 1, so in0 wins the first tie.
  - Combinational outputs then read: all accepts/acks 0, out_rd_o=0, out_wr_o=0, outstanding_o=0.
  - Reset mid-operation discards in-flight tracking. The bridge must be reset in the same cycle.

Decomposition:
- Package dport_arb_pkg:
  - localparams PORT_IN0=1'b0, PORT_IN1=1'b1, ADDR_W=32, DATA_W=32, TAG_W=11, STRB_W=4.
  - Function req_valid(rd, wr).
- One sub-module, dport_arb_order_fifo:
  - 1-bit-wide, OUTSTANDING-deep sync FIFO with push/pop/valid/accept/count.
  - Synchronous active-low reset.

Test Plan:
- Single port: in0 read addr 0x100 tag 0x05, out_accept_i=1 -> in0_accept_o same cycle; out_ack_i two cycles later with data 0xDEADBEEF -> in0_ack_o=1, in1_ack_o=0, resp_tag 0x05.
- Round-robin: both ports request continuously, FIXED_PRIO=0 -> grant sequence in0,in1,in0,in1. FIXED_PRIO=1 -> in0 only while it requests.
- Hold: in1 granted with out_accept_i=0 for 3 cycles while in0 asserts -> out_* stay on in1, in0_accept_o=0; on cycle 4 in1 accepted, in0 granted next.
- Full/ordering: 4 accepts (in0,in1,in1,in0) with no acks -> outstanding_o=4, a 5th request is stalled with out_rd_o=0. Acks route in order in0,in1,in1,in0. An ack with a same-cycle request leaves count at 4 until the next cycle.
- Spurious/reset: out_ack_i with empty FIFO -> no inN_ack_o, spurious_o=1 and held. rst_i=0 with 2 outstanding -> outstanding_o=0, spurious_o=0, next tie granted to in0.
